// File: rtl/dla_pkg.sv
// Shared constants and arithmetic helpers for the DLA accumulate/requantize datapath.
package dla_pkg;

    localparam int unsigned PSUM_W  = 35;
    localparam int unsigned ACC_W   = 48;
    localparam int unsigned BIAS_W  = 32;
    localparam int unsigned OUT_W   = 16;
    localparam int unsigned SHIFT_W = 6;

    // Two guard bits hold acc + psum + bias without wrapping before saturation.
    localparam int unsigned SUM_W = ACC_W + 2;

    typedef struct packed {
        logic                    clip;
        logic signed [ACC_W-1:0] val;
    } acc_sat_t;

    typedef struct packed {
        logic                    clip;
        logic signed [OUT_W-1:0] val;
    } out_sat_t;

    function automatic acc_sat_t sat_acc(input logic signed [SUM_W-1:0] x);
        acc_sat_t res;
        res.clip = (x[SUM_W-1:ACC_W-1] != {(SUM_W-ACC_W+1){x[SUM_W-1]}});
        if (res.clip) begin
            res.val = x[SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            res.val = x[ACC_W-1:0];
        end
        return res;
    endfunction

    function automatic out_sat_t sat_out(input logic signed [ACC_W:0] x);
        out_sat_t res;
        res.clip = (x[ACC_W:OUT_W-1] != {(ACC_W-OUT_W+2){x[ACC_W]}});
        if (res.clip) begin
            res.val = x[ACC_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end else begin
            res.val = x[OUT_W-1:0];
        end
        return res;
    endfunction

    // Round-half-up arithmetic right shift; one extra bit keeps the rounding add from overflowing.
    function automatic logic signed [ACC_W:0] rshift_rnd(input logic signed [ACC_W-1:0] x,
                                                         input logic [SHIFT_W-1:0]  sh);
        logic signed [ACC_W:0] ext;
        logic signed [ACC_W:0] rnd;
        logic signed [ACC_W:0] sum;
        ext = {x[ACC_W-1], x};
        rnd = '0;
        if (sh != '0) begin
            rnd = (ACC_W+1)'(1) << (sh - SHIFT_W'(1));
        end
        sum = ext + rnd;
        return sum >>> sh;
    endfunction

endpackage

// File: rtl/dla_requant.sv
// Combinational requantizer: rounding shift, optional ReLU, saturation to the output width.
module dla_requant
    import dla_pkg::*;
(
    input  logic signed [ACC_W-1:0]   sum_i,
    input  logic        [SHIFT_W-1:0] shift_i,
    input  logic                      relu_i,
    output logic signed [OUT_W-1:0]   data_o,
    output logic                      clip_o
);

    logic signed [ACC_W:0] shifted;
    out_sat_t              sat;

    always_comb begin
        shifted = rshift_rnd(sum_i, shift_i);
        // ReLU happens before saturation so zeroing never counts as a clip.
        if (relu_i && shifted[ACC_W]) begin
            shifted = '0;
        end
        sat    = sat_out(shifted);
        data_o = sat.val;
        clip_o = sat.clip;
    end

endmodule

// File: rtl/dla_accum_quant.sv
// Accumulates partial dot products, adds bias and requantizes onto a valid/ready output stream.
module dla_accum_quant
    import dla_pkg::*;
(
    input  logic                      dla_core_clk,
    input  logic                      dla_reset,
    input  logic signed [PSUM_W-1:0]  psum_in,
    input  logic                      psum_valid,
    input  logic                      psum_last,
    output logic                      psum_ready,
    input  logic signed [BIAS_W-1:0]  bias_in,
    input  logic        [SHIFT_W-1:0] shift_in,
    input  logic                      relu_en,
    output logic signed [OUT_W-1:0]   out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      sat_flag
);

    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [ACC_W-1:0]   s1_sum_q, s1_sum_d;
    logic        [SHIFT_W-1:0] s1_shift_q, s1_shift_d;
    logic                      s1_relu_q, s1_relu_d;
    logic                      s1_v_q, s1_v_d;
    logic signed [OUT_W-1:0]   out_data_q, out_data_d;
    logic                      out_valid_q, out_valid_d;
    logic                      sat_q, sat_d;

    logic                      beat;
    logic                      out_load;
    logic signed [SUM_W-1:0]   beat_sum;
    logic signed [SUM_W-1:0]   last_sum;
    logic        [SHIFT_W-1:0] shift_clamped;
    acc_sat_t                  acc_sat;
    acc_sat_t                  s1_sat;
    logic signed [OUT_W-1:0]   rq_data;
    logic                      rq_clip;

    assign psum_ready = !s1_v_q || !out_valid_q || out_ready;
    assign beat       = psum_valid && psum_ready;
    assign out_load   = s1_v_q && (!out_valid_q || out_ready);

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign sat_flag  = sat_q;

    always_comb begin
        beat_sum = {{(SUM_W-ACC_W){acc_q[ACC_W-1]}}, acc_q}
                 + {{(SUM_W-PSUM_W){psum_in[PSUM_W-1]}}, psum_in};
        last_sum = beat_sum + {{(SUM_W-BIAS_W){bias_in[BIAS_W-1]}}, bias_in};
        acc_sat  = sat_acc(beat_sum);
        s1_sat   = sat_acc(last_sum);
        // Out-of-range shifts are clamped rather than trusted.
        shift_clamped = (shift_in >= SHIFT_W'(ACC_W)) ? SHIFT_W'(ACC_W - 1) : shift_in;
    end

    dla_requant u_requant (
        .sum_i   (s1_sum_q),
        .shift_i (s1_shift_q),
        .relu_i  (s1_relu_q),
        .data_o  (rq_data),
        .clip_o  (rq_clip)
    );

    always_comb begin
        acc_d       = acc_q;
        s1_sum_d    = s1_sum_q;
        s1_shift_d  = s1_shift_q;
        s1_relu_d   = s1_relu_q;
        s1_v_d      = s1_v_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        sat_d       = sat_q;

        if (out_load) begin
            s1_v_d      = 1'b0;
            out_data_d  = rq_data;
            out_valid_d = 1'b1;
            sat_d       = sat_d | rq_clip;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // A new last beat may refill s1 in the same cycle it drains into the output register.
        if (beat) begin
            if (psum_last) begin
                s1_sum_d   = s1_sat.val;
                s1_shift_d = shift_clamped;
                s1_relu_d  = relu_en;
                s1_v_d     = 1'b1;
                acc_d      = '0;
                sat_d      = sat_d | s1_sat.clip;
            end else begin
                acc_d = acc_sat.val;
                sat_d = sat_d | acc_sat.clip;
            end
        end
    end

    always_ff @(posedge dla_core_clk or posedge dla_reset) begin
        if (dla_reset) begin
            acc_q       <= '0;
            s1_sum_q    <= '0;
            s1_shift_q  <= '0;
            s1_relu_q   <= 1'b0;
            s1_v_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            s1_sum_q    <= s1_sum_d;
            s1_shift_q  <= s1_shift_d;
            s1_relu_q   <= s1_relu_d;
            s1_v_q      <= s1_v_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            sat_q       <= sat_d;
        end
    end

endmodule

// File: tb/tb_dla_accum_quant.sv
// Scoreboard bench for dla_accum_quant using directed one- and multi-beat dot products.
module tb_dla_accum_quant;

    logic               clk;
    logic               rst;
    logic signed [34:0] psum_in;
    logic               psum_valid;
    logic               psum_last;
    logic               psum_ready;
    logic signed [31:0] bias_in;
    logic        [5:0]  shift_in;
    logic               relu_en;
    logic signed [15:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic               sat_flag;

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    dla_accum_quant dut (
        .dla_core_clk (clk),
        .dla_reset    (rst),
        .psum_in      (psum_in),
        .psum_valid   (psum_valid),
        .psum_last    (psum_last),
        .psum_ready   (psum_ready),
        .bias_in      (bias_in),
        .shift_in     (shift_in),
        .relu_en      (relu_en),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .sat_flag     (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Monitor: a transfer completes on the next rising edge when valid and ready are both high.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0d expected none", $signed(out_data));
            end else begin
                check("out_data", longint'($signed(out_data)), longint'(exp_q.pop_front()));
            end
        end
    end

    task automatic send(input longint p, input bit last, input int bias, input int sh,
                        input bit relu, input bit push, input int exp);
        int n;
        psum_in    = 35'(p);
        psum_last  = last;
        bias_in    = bias;
        shift_in   = 6'(sh);
        relu_en    = relu;
        psum_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!psum_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!psum_ready) check("accept_timeout", 0, 1);
        if (push) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        psum_valid = 1'b0;
        psum_last  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_remaining", exp_q.size(), 0);
    endtask

    initial begin
        rst        = 1'b1;
        psum_in    = '0;
        psum_valid = 1'b0;
        psum_last  = 1'b0;
        bias_in    = '0;
        shift_in   = '0;
        relu_en    = 1'b0;
        out_ready  = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_sat_flag", sat_flag, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_reset", psum_ready, 1);

        // 1: three-beat dot product with bias, latency two cycles after the last beat.
        send(100, 0, 0, 0, 0, 0, 0);
        send(200, 0, 0, 0, 0, 0, 0);
        send(-50, 1, 10, 0, 0, 1, 260);
        check("latency_t1_valid", out_valid, 0);
        @(posedge clk);
        #1;
        check("latency_t2_valid", out_valid, 1);
        check("latency_t2_data", longint'($signed(out_data)), 260);
        drain();
        check("sat_after_t1", sat_flag, 0);

        // 2: rounding shifts.
        send(6144, 1, 0, 4, 0, 1, 384);
        send(24, 1, 0, 4, 0, 1, 2);
        send(-24, 1, 0, 4, 0, 1, -1);
        drain();

        // 3: ReLU does not flag; output clipping does.
        send(-500, 1, 0, 0, 1, 1, 0);
        drain();
        check("sat_after_relu", sat_flag, 0);
        send(40000, 1, 0, 0, 0, 1, 32767);
        drain();
        check("sat_after_clip", sat_flag, 1);
        send(-40000, 1, 0, 0, 0, 1, -32768);
        send(100, 1, 0, 63, 0, 1, 0);
        drain();

        // 4: stall with three queued results.
        out_ready = 1'b0;
        send(1, 1, 0, 0, 0, 1, 1);
        send(2, 1, 0, 0, 0, 1, 2);
        psum_in    = 35'sd3;
        psum_last  = 1'b1;
        psum_valid = 1'b1;
        exp_q.push_back(3);
        @(negedge clk);
        check("stall_ready", psum_ready, 0);
        check("stall_out_valid", out_valid, 1);
        check("stall_out_data", longint'($signed(out_data)), 1);
        repeat (3) @(negedge clk);
        check("stall_ready_held", psum_ready, 0);
        check("stall_data_held", longint'($signed(out_data)), 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!psum_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("stall_release_ready", psum_ready, 1);
        end
        @(posedge clk);
        #1;
        psum_valid = 1'b0;
        psum_last  = 1'b0;
        drain();

        // 5: back-to-back one-beat dot products.
        psum_valid = 1'b1;
        psum_last  = 1'b1;
        shift_in   = '0;
        bias_in    = '0;
        relu_en    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            psum_in = 35'(i + 10);
            exp_q.push_back(i + 10);
            @(negedge clk);
            check("b2b_ready", psum_ready, 1);
            if (i >= 2) check("b2b_out_valid", out_valid, 1);
            @(posedge clk);
            #1;
        end
        psum_valid = 1'b0;
        psum_last  = 1'b0;
        drain();

        // 6: reset mid dot product with a result parked at the output.
        out_ready = 1'b0;
        send(5, 1, 0, 0, 0, 0, 0);
        send(3, 0, 0, 0, 0, 0, 0);
        send(4, 0, 0, 0, 0, 0, 0);
        check("pre_reset_out_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("reset_drops_valid", out_valid, 0);
        check("reset_clears_sat", sat_flag, 0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        send(7, 1, 0, 0, 0, 1, 7);
        drain();
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
